dom_rx_arbiter: RTL and testbench
=================================

// Module: dom_rx_arbiter
// PURPOSE
//   Round-robin arbiter sharing the destination-domain reception path between N_REQ requesters.
//   Grants one requester at a time for a burst of up to MAX_BURST words.
//   Forwards each accepted word as a registered valid_o/data_o strobe to the reception stage.
//   Sits directly upstream of the reception register, in the same clock domain.
// PARAMETERS
//   N_REQ     4  number of requesters (2..8)
//   DATA_W    8  word width
//   MAX_BURST 4  max words per grant (>=1); burst counter width $clog2(MAX_BURST+1)
// PORTS
//   clk_i       in   1             destination-domain clock
//   resetn_i    in   1             asynchronous active-low reset
//   req_valid_i in   N_REQ         per-requester word valid
//   req_data_i  in   N_REQ*DATA_W  packed words; requester k at [k*DATA_W +: DATA_W]
//   req_ready_o out  N_REQ         per-requester accept (combinational)
//   grant_o     out  N_REQ         one-hot registered grant, 0 when idle
//   sink_stall_i in  1             downstream back-pressure; 1 blocks all transfers
//   valid_o     out  1             one-cycle strobe to reception stage
//   data_o      out  DATA_W        word accompanying valid_o
//   src_id_o    out  $clog2(N_REQ) index of requester that produced data_o
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, grant_o=0, rr_ptr=0, burst_cnt=0, valid_o=0, data_o=0, src_id_o=0.
//   FSM states IDLE, BURST. Registered state, grant, pointer, count; req_ready_o decoded from them.
//   IDLE: if any req_valid_i, grant first asserted index searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//     Next cycle: state=BURST, grant_o one-hot, burst_cnt=0. No transfer in the IDLE cycle.
//   BURST, granted index g:
//     req_ready_o[g] = !sink_stall_i; all other req_ready_o bits 0.
//     Transfer when req_valid_i[g] && req_ready_o[g]: burst_cnt+1.
//     Next cycle: valid_o=1, data_o=word, src_id_o=g. Latency = 1 cycle.
//     valid_o=0 in every cycle following a non-transfer cycle. data_o/src_id_o hold last value.
//   Release, evaluated in the same cycle:
//     (a) transfer with burst_cnt==MAX_BURST-1, or (b) req_valid_i[g]==0.
//     Next cycle: state=IDLE, grant_o=0, rr_ptr=(g+1) mod N_REQ, burst_cnt=0.
//     Release forces a mandatory one-cycle idle gap before the next grant.
//   Stall: while sink_stall_i=1 with req_valid_i[g]=1, grant held, burst_cnt frozen, no timeout.
//   Stall with req_valid_i[g]=0 still releases per (b).
//   Fairness: after a grant, requester g has lowest priority for the next arbitration.
//     With N_REQ requesters continuously valid, each waits at most N_REQ-1 bursts.
//   MAX_BURST=1: every transfer releases; strict word-by-word round-robin with idle gaps.
//   rr_ptr wraps N_REQ-1 -> 0. burst_cnt never exceeds MAX_BURST-1 between transfers.
//   Non-granted requesters are never accepted; their data is ignored and must be held by the source.
// TESTING
//   1 Reset: resetn_i=0 with valid requests -> all outputs 0, req_ready_o=0.
//     Release reset -> grant_o=4'b0001 two cycles after first req_valid_i[0].
//   2 Burst cap, MAX_BURST=4: req0 continuously valid with 0xA0..0xA5.
//     -> valid_o pulses with 0xA0..0xA3, src_id=0, then one idle cycle, then re-grant to req0.
//   3 Round-robin: all 4 requesters continuously valid.
//     -> grant order 0,1,2,3,0, each 4 words, 1-cycle gap between bursts, src_id_o matches.
//   4 Early release: req2 granted, drops valid after 2 words.
//     -> grant_o=0 next cycle, rr_ptr=3, req3 granted next if valid.
//   5 Stall: mid-burst sink_stall_i=1 for 3 cycles.
//     -> req_ready_o=0, valid_o=0 for those 3 cycles, grant held.
//     Resume: remaining words delivered, total 4, no word lost or duplicated.
//   6 Reset mid-burst after 2 words.
//     -> immediate return to reset values; first grant after reset goes to req0.

Source files
------------

// File: rtl/dom_rx_arbiter_if.sv
// Requester-side and reception-side signal bundle for dom_rx_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and the stall line and observes the outputs.
interface dom_rx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ-1:0]        grant_o;
  logic                    sink_stall_i;
  logic                    valid_o;
  logic [DATA_W-1:0]       data_o;
  logic [IW-1:0]           src_id_o;

  modport slave (
    input  req_valid_i, req_data_i, sink_stall_i,
    output req_ready_o, grant_o, valid_o, data_o, src_id_o
  );

  modport master (
    output req_valid_i, req_data_i, sink_stall_i,
    input  req_ready_o, grant_o, valid_o, data_o, src_id_o
  );
endinterface

// File: rtl/dom_rx_arbiter.sv
// Round-robin arbiter that shares the destination-domain reception path
// between N_REQ requesters. One requester is granted at a time for a burst of
// up to MAX_BURST words; each accepted word is re-issued one cycle later as a
// registered valid_o/data_o/src_id_o strobe.
//
// Handshake: a word moves from requester k when req_valid_i[k] and
// req_ready_o[k] are both high in the same cycle. req_ready_o is only ever
// high for the granted requester and only while sink_stall_i is low; the
// source must hold its word stable until it is accepted. valid_o is a
// one-cycle strobe with no back-pressure of its own.
module dom_rx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  dom_rx_arbiter_if.slave                bus,
  output logic                           dbg_state_o,
  output logic [$clog2(N_REQ)-1:0]       dbg_rr_ptr_o,
  output logic [$clog2(MAX_BURST+1)-1:0] dbg_burst_cnt_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  idx_t               gidx_q, gidx_d;
  idx_t               rr_ptr_q, rr_ptr_d;
  cnt_t               burst_cnt_q, burst_cnt_d;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  idx_t               src_q;

  logic               arb_found;
  idx_t               arb_idx;
  logic [N_REQ-1:0]   ready_c;
  logic               xfer;
  logic               release_c;
  logic               last_word;
  idx_t               rr_after_g;
  logic [DATA_W-1:0]  granted_word;

  // Search for the first valid requester starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!arb_found && bus.req_valid_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = idx_t'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  // Ready is decoded from the registered grant; only the granted requester sees it, and stall masks it.
  always_comb begin
    ready_c = '0;
    if (state_q == BURST && !bus.sink_stall_i) begin
      ready_c[gidx_q] = 1'b1;
    end
  end

  assign xfer         = (state_q == BURST) && bus.req_valid_i[gidx_q] && ready_c[gidx_q];
  assign last_word    = (burst_cnt_q == cnt_t'(MAX_BURST - 1));
  // Releasing on a dropped valid applies even while stalled, so a stalled idle source cannot hog the path.
  assign release_c    = (state_q == BURST) && (!bus.req_valid_i[gidx_q] || (xfer && last_word));
  assign rr_after_g   = (gidx_q == idx_t'(N_REQ - 1)) ? idx_t'(0) : idx_t'(gidx_q + 1'b1);
  assign granted_word = bus.req_data_i[gidx_q*DATA_W +: DATA_W];

  // Next-state logic: grant from IDLE, count transfers and release from BURST.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d     = BURST;
          grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
          gidx_d      = arb_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (release_c) begin
          // The granted requester drops to lowest priority for the next search.
          state_d     = IDLE;
          grant_d     = '0;
          rr_ptr_d    = rr_after_g;
          burst_cnt_d = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Control registers: FSM state, grant, round-robin pointer and burst count.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output strobe register: valid pulses for exactly the cycle after a transfer; data/src hold otherwise.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= xfer;
      if (xfer) begin
        data_q <= granted_word;
        src_q  <= gidx_q;
      end
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.grant_o     = grant_q;
  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.src_id_o    = src_q;

  assign dbg_state_o     = state_q;
  assign dbg_rr_ptr_o    = rr_ptr_q;
  assign dbg_burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_dom_rx_arbiter.sv
// Directed bench for dom_rx_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are compared 1 time unit later,
// so registered outputs reflect the previous rising edge and req_ready_o
// reflects the current inputs.
module tb_dom_rx_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dom_rx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  logic       dbg_state;
  logic [1:0] dbg_rr_ptr;
  logic [2:0] dbg_burst_cnt;

  dom_rx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
    .bus             (bus.slave),
    .dbg_state_o     (dbg_state),
    .dbg_rr_ptr_o    (dbg_rr_ptr),
    .dbg_burst_cnt_o (dbg_burst_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        stall;
    logic [3:0]  e_ready;
    logic [3:0]  e_grant;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [1:0]  e_src;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input string nm, input logic r, input logic [3:0] v,
                              input logic [31:0] d, input logic s, input logic [3:0] er,
                              input logic [3:0] eg, input logic ev, input logic [7:0] ed,
                              input logic [1:0] es);
    vec_t t;
    t.name = nm; t.rst_n = r; t.valid = v; t.data = d; t.stall = s;
    t.e_ready = er; t.e_grant = eg; t.e_valid = ev; t.e_data = ed; t.e_src = es;
    return t;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver: one cycle of stimulus plus output comparison ----------------
  task automatic cycle(input string nm, input logic r, input logic [3:0] v,
                       input logic [31:0] d, input logic s, input logic [3:0] er,
                       input logic [3:0] eg, input logic ev, input logic [7:0] ed,
                       input logic [1:0] es);
    @(negedge clk);
    resetn           = r;
    bus.req_valid_i  = v;
    bus.req_data_i   = d;
    bus.sink_stall_i = s;
    #1;
    chk({nm, ".ready"}, 32'(bus.req_ready_o), 32'(er));
    chk({nm, ".grant"}, 32'(bus.grant_o),     32'(eg));
    chk({nm, ".valid"}, 32'(bus.valid_o),     32'(ev));
    chk({nm, ".data"},  32'(bus.data_o),      32'(ed));
    chk({nm, ".src"},   32'(bus.src_id_o),    32'(es));
  endtask

  // Round-robin scenario model state
  logic [7:0] wcnt[4];
  logic [7:0] last_d;
  logic [1:0] last_s;
  logic       exp_v;

  function automatic logic [31:0] rr_bus();
    logic [31:0] b;
    for (int k = 0; k < 4; k++) b[k*8 +: 8] = 8'(8'h10 * (k + 1)) + wcnt[k];
    return b;
  endfunction

  initial begin
    bus.req_valid_i  = '0;
    bus.req_data_i   = '0;
    bus.sink_stall_i = 1'b0;

    // Reset with a pending request, then a capped burst from req0 and a re-grant.
    tbl[0]  = mk("rst0",     0, 4'b0001, 32'h0000_00A0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
    tbl[1]  = mk("rst1",     0, 4'b0001, 32'h0000_00A0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
    tbl[2]  = mk("idle0",    1, 4'b0001, 32'h0000_00A0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
    tbl[3]  = mk("g0_w0",    1, 4'b0001, 32'h0000_00A0, 0, 4'h1, 4'h1, 0, 8'h00, 0);
    tbl[4]  = mk("g0_w1",    1, 4'b0001, 32'h0000_00A1, 0, 4'h1, 4'h1, 1, 8'hA0, 0);
    tbl[5]  = mk("g0_w2",    1, 4'b0001, 32'h0000_00A2, 0, 4'h1, 4'h1, 1, 8'hA1, 0);
    tbl[6]  = mk("g0_w3",    1, 4'b0001, 32'h0000_00A3, 0, 4'h1, 4'h1, 1, 8'hA2, 0);
    tbl[7]  = mk("cap_gap",  1, 4'b0001, 32'h0000_00A4, 0, 4'h0, 4'h0, 1, 8'hA3, 0);
    tbl[8]  = mk("regrant",  1, 4'b0001, 32'h0000_00A4, 0, 4'h1, 4'h1, 0, 8'hA3, 0);
    tbl[9]  = mk("g0_w5",    1, 4'b0001, 32'h0000_00A5, 0, 4'h1, 4'h1, 1, 8'hA4, 0);
    tbl[10] = mk("drop0",    1, 4'b0000, 32'h0000_0000, 0, 4'h1, 4'h1, 1, 8'hA5, 0);
    tbl[11] = mk("idle_end", 1, 4'b0000, 32'h0000_0000, 0, 4'h0, 4'h0, 0, 8'hA5, 0);

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].name, tbl[i].rst_n, tbl[i].valid, tbl[i].data, tbl[i].stall,
            tbl[i].e_ready, tbl[i].e_grant, tbl[i].e_valid, tbl[i].e_data, tbl[i].e_src);
      if (i == 1) chk("rst_state", 32'(dbg_state), 32'd0);
    end

    // Round-robin with all four requesters continuously valid.
    cycle("rr_rst", 0, 4'b0000, 32'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
    chk("rr_rst_ptr", 32'(dbg_rr_ptr), 32'd0);
    for (int k = 0; k < 4; k++) wcnt[k] = 8'h00;
    last_d = 8'h00;
    last_s = 2'd0;
    exp_v  = 1'b0;
    for (int b = 0; b < 5; b++) begin
      logic [1:0] g;
      logic [3:0] oh;
      g  = 2'(b % 4);
      oh = 4'b0001 << g;
      cycle($sformatf("rr%0d_gap", b), 1, 4'b1111, rr_bus(), 0, 4'h0, 4'h0, exp_v, last_d, last_s);
      exp_v = 1'b0;
      for (int j = 0; j < 4; j++) begin
        cycle($sformatf("rr%0d_w%0d", b, j), 1, 4'b1111, rr_bus(), 0, oh, oh, exp_v, last_d, last_s);
        last_d  = 8'(8'h10 * (int'(g) + 1)) + wcnt[g];
        last_s  = g;
        wcnt[g] = wcnt[g] + 8'd1;
        exp_v   = 1'b1;
      end
    end

    // Early release: req2 granted (rr_ptr=1), drops valid after two words; req3 follows.
    cycle("s4_idle",  1, 4'b1100, 32'hD0C0_0000, 0, 4'h0, 4'h0, 1, last_d, last_s);
    cycle("s4_g2",    1, 4'b1100, 32'hD0C0_0000, 0, 4'h4, 4'h4, 0, last_d, last_s);
    cycle("s4_w1",    1, 4'b1100, 32'hD0C1_0000, 0, 4'h4, 4'h4, 1, 8'hC0, 2);
    cycle("s4_drop",  1, 4'b1000, 32'hD000_0000, 0, 4'h4, 4'h4, 1, 8'hC1, 2);
    cycle("s4_gap",   1, 4'b1000, 32'hD000_0000, 0, 4'h0, 4'h0, 0, 8'hC1, 2);
    chk("s4_rr_ptr", 32'(dbg_rr_ptr), 32'd3);
    cycle("s4_g3",    1, 4'b1000, 32'hD000_0000, 0, 4'h8, 4'h8, 0, 8'hC1, 2);
    cycle("s4_drop3", 1, 4'b0000, 32'h0000_0000, 0, 4'h8, 4'h8, 1, 8'hD0, 3);
    cycle("s4_idle2", 1, 4'b0000, 32'h0000_0000, 0, 4'h0, 4'h0, 0, 8'hD0, 3);

    // Stall for three cycles mid-burst on req1; all four words must arrive exactly once.
    cycle("s5_idle",   1, 4'b0010, 32'h0000_E000, 0, 4'h0, 4'h0, 0, 8'hD0, 3);
    cycle("s5_g1",     1, 4'b0010, 32'h0000_E000, 0, 4'h2, 4'h2, 0, 8'hD0, 3);
    cycle("s5_w1",     1, 4'b0010, 32'h0000_E100, 0, 4'h2, 4'h2, 1, 8'hE0, 1);
    cycle("s5_stall0", 1, 4'b0010, 32'h0000_E200, 1, 4'h0, 4'h2, 1, 8'hE1, 1);
    cycle("s5_stall1", 1, 4'b0010, 32'h0000_E200, 1, 4'h0, 4'h2, 0, 8'hE1, 1);
    chk("s5_cnt_frozen", 32'(dbg_burst_cnt), 32'd2);
    cycle("s5_stall2", 1, 4'b0010, 32'h0000_E200, 1, 4'h0, 4'h2, 0, 8'hE1, 1);
    cycle("s5_resume", 1, 4'b0010, 32'h0000_E200, 0, 4'h2, 4'h2, 0, 8'hE1, 1);
    cycle("s5_w3",     1, 4'b0010, 32'h0000_E300, 0, 4'h2, 4'h2, 1, 8'hE2, 1);
    cycle("s5_rel",    1, 4'b0000, 32'h0000_0000, 0, 4'h0, 4'h0, 1, 8'hE3, 1);
    cycle("s5_gap",    1, 4'b0000, 32'h0000_0000, 0, 4'h0, 4'h0, 0, 8'hE3, 1);

    // Reset mid-burst (rr_ptr=2, req3 granted); afterwards req0 must win from rr_ptr=0.
    cycle("s6_idle",  1, 4'b1000, 32'hF000_0000, 0, 4'h0, 4'h0, 0, 8'hE3, 1);
    cycle("s6_g3",    1, 4'b1000, 32'hF000_0000, 0, 4'h8, 4'h8, 0, 8'hE3, 1);
    cycle("s6_w1",    1, 4'b1000, 32'hF100_0000, 0, 4'h8, 4'h8, 1, 8'hF0, 3);
    cycle("s6_rst",   0, 4'b1000, 32'hF200_0000, 0, 4'h0, 4'h0, 0, 8'h00, 0);
    chk("s6_rst_ptr", 32'(dbg_rr_ptr), 32'd0);
    chk("s6_rst_cnt", 32'(dbg_burst_cnt), 32'd0);
    cycle("s6_rst2",  0, 4'b1011, 32'hF200_00B0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
    cycle("s6_idle2", 1, 4'b1011, 32'hF200_00B0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
    cycle("s6_g0",    1, 4'b1011, 32'hF200_00B0, 0, 4'h1, 4'h1, 0, 8'h00, 0);
    cycle("s6_w1b",   1, 4'b0000, 32'h0000_0000, 0, 4'h1, 4'h1, 1, 8'hB0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
